// File: rtl/read_only_input_reg_if.sv
// System-side bundle for the read-only input register.
// The raw I/O bus travels with the CPU read/status signals.
interface read_only_input_reg_if #(
    parameter int WID_DATA = 32
);
    logic [WID_DATA-1:0] IO_DataIn;
    logic                Sys_RE;
    logic                Sys_IntEn;
    logic [WID_DATA-1:0] Sys_DataOut;
    logic                Sys_Changed;
    logic                Sys_Overrun;
    logic                Sys_IntReq;

    modport master (
        output IO_DataIn,
        output Sys_RE,
        output Sys_IntEn,
        input  Sys_DataOut,
        input  Sys_Changed,
        input  Sys_Overrun,
        input  Sys_IntReq
    );

    modport slave (
        input  IO_DataIn,
        input  Sys_RE,
        input  Sys_IntEn,
        output Sys_DataOut,
        output Sys_Changed,
        output Sys_Overrun,
        output Sys_IntReq
    );
endinterface

// File: rtl/read_only_input_reg.sv
// Synchronizes an async input bus, debounces it over a stability window
// and holds the accepted value with sticky change/overrun status.
module read_only_input_reg #(
    parameter int                  WID_DATA      = 32,
    parameter logic [WID_DATA-1:0] RST_VALUE     = '0,
    parameter int                  STABLE_CYCLES = 4
) (
    input logic            Clock,
    input logic            Reset,
    read_only_input_reg_if.slave sys
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

    logic [WID_DATA-1:0] s1;
    logic [WID_DATA-1:0] s2;
    logic [WID_DATA-1:0] cand;
    logic [WID_DATA-1:0] data_q;
    logic [CW-1:0]       cnt;
    logic                changed_q;
    logic                overrun_q;
    logic                int_req_q;
    logic                capture;

    // s1/s2 form the synchronizer; cand is the value under observation
    always_ff @(posedge Clock) begin
        if (Reset) begin
            s1   <= RST_VALUE;
            s2   <= RST_VALUE;
            cand <= RST_VALUE;
        end else begin
            s1   <= sys.IO_DataIn;
            s2   <= s1;
            cand <= s2;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            cnt <= '0;
        end else if (s2 != cand) begin
            cnt <= '0;
        end else if (cnt < CNT_MAX) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Only a value that differs from the held one raises an event
    assign capture = (cnt == CNT_MAX) && (cand != data_q);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            data_q <= RST_VALUE;
        end else if (capture) begin
            data_q <= cand;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            changed_q <= 1'b0;
            overrun_q <= 1'b0;
            int_req_q <= 1'b0;
        end else begin
            int_req_q <= capture & sys.Sys_IntEn;
            unique case ({capture, sys.Sys_RE})
                2'b11: begin
                    changed_q <= 1'b1;
                    overrun_q <= 1'b0;
                end
                2'b10: begin
                    changed_q <= 1'b1;
                    overrun_q <= overrun_q | changed_q;
                end
                2'b01: begin
                    changed_q <= 1'b0;
                    overrun_q <= 1'b0;
                end
                default: begin
                    changed_q <= changed_q;
                    overrun_q <= overrun_q;
                end
            endcase
        end
    end

    assign sys.Sys_DataOut = data_q;
    assign sys.Sys_Changed = changed_q;
    assign sys.Sys_Overrun = overrun_q;
    assign sys.Sys_IntReq  = int_req_q;
endmodule

// File: tb/tb_read_only_input_reg.sv
// Bench for read_only_input_reg: vector table, corner sequences and
// randomized traffic against a sample-history reference model.
module tb_read_only_input_reg;
    localparam int W = 32;
    localparam int N = 4;
    localparam logic [W-1:0] RV = '0;

    typedef struct {
        logic [W-1:0] din;
        bit           re;
        bit           ie;
        bit           rst;
        logic [W-1:0] out;
        bit           chg;
        bit           ovr;
        bit           irq;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    read_only_input_reg_if #(.WID_DATA(W)) sys ();

    read_only_input_reg #(
        .WID_DATA(W),
        .RST_VALUE(RV),
        .STABLE_CYCLES(N)
    ) dut (
        .Clock(clk),
        .Reset(rst),
        .sys(sys)
    );

    int n_chk = 0;
    int n_pass = 0;

    // Model: the raw samples seen since reset; a capture needs the
    // N+1 samples that have since drained into the filter to agree.
    logic [W-1:0] hist[$];
    logic [W-1:0] m_out;
    bit           m_chg;
    bit           m_ovr;
    bit           m_irq;

    function automatic void model_reset();
        hist = {RV, RV, RV};
        m_out = RV;
        m_chg = 0;
        m_ovr = 0;
        m_irq = 0;
    endfunction

    function automatic void model_edge(logic [W-1:0] d, bit re, bit ie);
        bit cap;
        logic [W-1:0] v;
        hist.push_back(d);
        if (hist.size() > N + 4) void'(hist.pop_front());
        cap = 0;
        v = hist[0];
        if (hist.size() == N + 4) begin
            cap = 1;
            for (int i = 0; i <= N; i++)
                if (hist[i] != v) cap = 0;
            if (v == m_out) cap = 0;
        end
        if (cap && re) begin
            m_chg = 1;
            m_ovr = 0;
        end else if (cap) begin
            m_ovr = m_ovr | m_chg;
            m_chg = 1;
        end else if (re) begin
            m_chg = 0;
            m_ovr = 0;
        end
        m_irq = cap & ie;
        if (cap) m_out = v;
    endfunction

    task automatic check(input string nm, input logic [W-1:0] act,
                         input logic [W-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    task automatic check_model(input string tag);
        check({tag, ".data"}, sys.Sys_DataOut, m_out);
        check({tag, ".chg"}, W'(sys.Sys_Changed), W'(m_chg));
        check({tag, ".ovr"}, W'(sys.Sys_Overrun), W'(m_ovr));
        check({tag, ".irq"}, W'(sys.Sys_IntReq), W'(m_irq));
    endtask

    task automatic cyc(input logic [W-1:0] d, input bit re, input bit ie,
                       input bit r, input string tag);
        sys.IO_DataIn = d;
        sys.Sys_RE    = re;
        sys.Sys_IntEn = ie;
        rst           = r;
        @(posedge clk);
        if (r) model_reset();
        else model_edge(d, re, ie);
        #1;
        if (tag != "") check_model(tag);
    endtask

    function automatic vec_t mk(logic [W-1:0] din, bit re, bit ie, bit r,
                                logic [W-1:0] out, bit chg, bit ovr, bit irq);
        vec_t v;
        v.din = din; v.re = re; v.ie = ie; v.rst = r;
        v.out = out; v.chg = chg; v.ovr = ovr; v.irq = irq;
        return v;
    endfunction

    vec_t tbl[12];
    bit   irq_seen;
    logic [W-1:0] rd;
    logic [W-1:0] pool[4];

    initial begin
        logic [W-1:0] a5;
        a5 = 32'hA5A5_0001;
        tbl[0] = mk('0, 0, 1, 1, '0, 0, 0, 0);
        tbl[1] = mk('0, 0, 1, 1, '0, 0, 0, 0);
        for (int i = 2; i < 9; i++) tbl[i] = mk(a5, 0, 1, 0, '0, 0, 0, 0);
        tbl[9]  = mk(a5, 0, 1, 0, a5, 1, 0, 1);
        tbl[10] = mk(a5, 0, 1, 0, a5, 1, 0, 0);
        tbl[11] = mk(a5, 1, 1, 0, a5, 0, 0, 0);

        sys.IO_DataIn = '0;
        sys.Sys_RE = 0;
        sys.Sys_IntEn = 0;
        rst = 1;

        // reset rows, then idle window with no interrupt
        for (int i = 0; i < 2; i++) begin
            cyc(tbl[i].din, tbl[i].re, tbl[i].ie, tbl[i].rst, "");
            check("tbl.data", sys.Sys_DataOut, tbl[i].out);
            check("tbl.chg", W'(sys.Sys_Changed), W'(tbl[i].chg));
            check("tbl.ovr", W'(sys.Sys_Overrun), W'(tbl[i].ovr));
            check("tbl.irq", W'(sys.Sys_IntReq), W'(tbl[i].irq));
        end
        irq_seen = 0;
        for (int i = 0; i < 20; i++) begin
            cyc('0, 0, 1, 0, "idle");
            if (sys.Sys_IntReq) irq_seen = 1;
        end
        check("idle.noirq", W'(irq_seen), '0);

        // A5A5_0001 latency: capture lands on edge N+4
        for (int i = 2; i < 12; i++) begin
            cyc(tbl[i].din, tbl[i].re, tbl[i].ie, tbl[i].rst, "");
            check("tbl.data", sys.Sys_DataOut, tbl[i].out);
            check("tbl.chg", W'(sys.Sys_Changed), W'(tbl[i].chg));
            check("tbl.ovr", W'(sys.Sys_Overrun), W'(tbl[i].ovr));
            check("tbl.irq", W'(sys.Sys_IntReq), W'(tbl[i].irq));
        end

        // glitch of 3 cycles is filtered out
        cyc('0, 0, 1, 1, "grst");
        irq_seen = 0;
        for (int i = 0; i < 3; i++) cyc(32'h1, 0, 1, 0, "glitch");
        for (int i = 0; i < 12; i++) begin
            cyc('0, 0, 1, 0, "glitch");
            if (sys.Sys_IntReq) irq_seen = 1;
        end
        check("glitch.data", sys.Sys_DataOut, '0);
        check("glitch.chg", W'(sys.Sys_Changed), '0);
        check("glitch.noirq", W'(irq_seen), '0);

        // overrun on two unread captures, then one read clears
        for (int i = 0; i < 10; i++) cyc(32'h10, 0, 1, 0, "ovr");
        for (int i = 0; i < 10; i++) cyc(32'h20, 0, 1, 0, "ovr");
        check("ovr.data", sys.Sys_DataOut, 32'h20);
        check("ovr.flag", W'(sys.Sys_Overrun), W'(1));
        check("ovr.read_data", sys.Sys_DataOut, 32'h20);
        cyc(32'h20, 1, 1, 0, "ovr.rd");
        check("ovr.clr_chg", W'(sys.Sys_Changed), '0);
        check("ovr.clr_ovr", W'(sys.Sys_Overrun), '0);

        // read on the capture edge with Sys_Changed already set
        for (int i = 0; i < 10; i++) cyc(32'h33, 0, 0, 0, "rdcap");
        check("rdcap.pre_chg", W'(sys.Sys_Changed), W'(1));
        for (int i = 0; i < N + 3; i++) cyc(32'h55, 0, 0, 0, "rdcap");
        check("rdcap.pre_data", sys.Sys_DataOut, 32'h33);
        cyc(32'h55, 1, 0, 0, "rdcap");
        check("rdcap.data", sys.Sys_DataOut, 32'h55);
        check("rdcap.chg", W'(sys.Sys_Changed), W'(1));
        check("rdcap.ovr", W'(sys.Sys_Overrun), '0);

        // reset with the counter part-way, then re-capture
        for (int i = 0; i < 5; i++) cyc(32'h77, 0, 1, 0, "mid");
        cyc(32'h77, 0, 1, 1, "mid.rst");
        check("mid.rst_data", sys.Sys_DataOut, RV);
        for (int i = 1; i <= N + 4; i++) begin
            cyc(32'h77, 0, 1, 0, "mid");
            if (i == N + 3) check("mid.before", sys.Sys_DataOut, RV);
        end
        check("mid.after", sys.Sys_DataOut, 32'h77);
        check("mid.irq", W'(sys.Sys_IntReq), W'(1));

        // randomized traffic
        pool[0] = '0;
        pool[1] = 32'hDEAD_BEEF;
        pool[2] = 32'h1;
        for (int k = 0; k < 60; k++) begin
            int run;
            pool[3] = $urandom;
            rd = pool[$urandom_range(0, 3)];
            run = $urandom_range(1, 9);
            for (int j = 0; j < run; j++) begin
                cyc(rd, ($urandom_range(0, 5) == 0), 1'($urandom),
                    ($urandom_range(0, 99) == 0), "rnd");
            end
        end

        sys.Sys_RE = 0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
